// File: rtl/alu_exc_unit_pkg.sv
// Shared exception definitions: cause codes and ALU status bit positions,
// common to the ALU, the decoder and the exception unit.
package alu_exc_unit_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_DIVZERO  = 2'd2,
    CAUSE_MULOVF   = 2'd3
  } cause_e;

  localparam int ST_MULOVF_BIT   = 6;
  localparam int ST_MISALIGN_BIT = 3;
  localparam int ST_DIVZERO_BIT  = 2;

  localparam int DATA_W   = 32;
  localparam int STATUS_W = 8;
  localparam int COUNT_W  = 8;

endpackage

// File: rtl/alu_exc_unit_if.sv
// EX-stage fault bus between the pipeline (master) and the exception unit
// (slave).
interface alu_exc_unit_if;
  import alu_exc_unit_pkg::*;

  logic                valid_in;
  logic [DATA_W-1:0]   pc_in;
  logic [DATA_W-1:0]   alu_result;
  logic [STATUS_W-1:0] alu_status;
  logic                chk_align;
  logic                chk_div;
  logic                chk_mulovf;
  logic                eret;
  logic                exc_flush;
  logic [DATA_W-1:0]   redirect_pc;
  logic                exc_pending;
  logic [DATA_W-1:0]   epc;
  logic [1:0]          cause;
  logic [DATA_W-1:0]   badvaddr;
  logic [COUNT_W-1:0]  exc_count;

  modport master (
    output valid_in, pc_in, alu_result, alu_status,
           chk_align, chk_div, chk_mulovf, eret,
    input  exc_flush, redirect_pc, exc_pending, epc, cause, badvaddr, exc_count
  );

  modport slave (
    input  valid_in, pc_in, alu_result, alu_status,
           chk_align, chk_div, chk_mulovf, eret,
    output exc_flush, redirect_pc, exc_pending, epc, cause, badvaddr, exc_count
  );

endinterface

// File: rtl/alu_exc_unit_prio_enc.sv
// Fixed-priority encoder: qualified faults to a single cause code.
// Misaligned beats divide-by-zero beats multiply overflow.
module exc_prio_enc
  import alu_exc_unit_pkg::*;
(
  input  logic       flt_align,
  input  logic       flt_div,
  input  logic       flt_mulovf,
  output logic       fault,
  output logic [1:0] cause
);

  always_comb begin
    fault = flt_align | flt_div | flt_mulovf;
    cause = CAUSE_NONE;
    if (flt_align)       cause = CAUSE_MISALIGN;
    else if (flt_div)    cause = CAUSE_DIVZERO;
    else if (flt_mulovf) cause = CAUSE_MULOVF;
  end

endmodule

// File: rtl/alu_exc_unit.sv
// EX-stage exception unit: accepts one fault, pulses a pipeline flush,
// then holds the exception until eret.
module alu_exc_unit
  import alu_exc_unit_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = 32'h8000_0180
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_exc_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                accept;
  logic                fault;
  logic [1:0]          cause_enc;
  logic                flush_q;
  logic                pending_q;
  logic [DATA_W-1:0]   epc_q;
  logic [1:0]          cause_q;
  logic [DATA_W-1:0]   badvaddr_q;
  logic [COUNT_W-1:0]  count_q;

  exc_prio_enc u_prio_enc (
    .flt_align  (bus.valid_in & bus.chk_align  & bus.alu_status[ST_MISALIGN_BIT]),
    .flt_div    (bus.valid_in & bus.chk_div    & bus.alu_status[ST_DIVZERO_BIT]),
    .flt_mulovf (bus.valid_in & bus.chk_mulovf & bus.alu_status[ST_MULOVF_BIT]),
    .fault      (fault),
    .cause      (cause_enc)
  );

  // eret is only honoured in HOLD, and there it outranks any new fault.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (fault) begin
          state_d = S_FLUSH;
          accept  = 1'b1;
        end
      end
      S_FLUSH: state_d = S_HOLD;
      S_HOLD:  if (bus.eret) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      flush_q    <= 1'b0;
      pending_q  <= 1'b0;
      epc_q      <= '0;
      cause_q    <= CAUSE_NONE;
      badvaddr_q <= '0;
      count_q    <= '0;
    end else begin
      state_q   <= state_d;
      flush_q   <= accept;
      pending_q <= (state_d != S_IDLE);
      if (accept) begin
        epc_q   <= bus.pc_in;
        cause_q <= cause_enc;
        if (cause_enc == CAUSE_MISALIGN) badvaddr_q <= bus.alu_result;
        if (count_q != {COUNT_W{1'b1}}) count_q <= count_q + 1'b1;
      end
    end
  end

  assign bus.exc_flush   = flush_q;
  assign bus.exc_pending = pending_q;
  assign bus.epc         = epc_q;
  assign bus.cause       = cause_q;
  assign bus.badvaddr    = badvaddr_q;
  assign bus.exc_count   = count_q;
  assign bus.redirect_pc = HANDLER_PC;

endmodule
